// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states, row one-hot
// drive patterns, the clear key code and small column-decode helpers.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      PRESSED  = 2'd2
   } state_t;

   localparam logic [3:0] ROW0 = 4'b0001;
   localparam logic [3:0] ROW1 = 4'b0010;
   localparam logic [3:0] ROW2 = 4'b0100;
   localparam logic [3:0] ROW3 = 4'b1000;

   localparam logic [3:0] KEY_CLEAR = 4'hF;

   function automatic logic [3:0] row_onehot(input logic [1:0] idx);
      logic [3:0] r;
      case (idx)
         2'd0:    r = ROW0;
         2'd1:    r = ROW1;
         2'd2:    r = ROW2;
         default: r = ROW3;
      endcase
      return r;
   endfunction

   function automatic logic one_hot4(input logic [3:0] v);
      return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
   endfunction

   function automatic logic [1:0] col_index(input logic [3:0] v);
      logic [1:0] idx;
      idx = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         if (v[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/keypad_scan_sync2.sv
// Two-flop synchronizer for the asynchronous keypad column inputs.
module sync2 (
   input  logic       clk190Hz,
   input  logic       rst,
   input  logic [3:0] d,
   output logic [3:0] q
);

   logic [3:0] meta;

   always_ff @(posedge clk190Hz or posedge rst) begin
      if (rst) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner/debouncer feeding a 4-nibble key history to the display driver.
// Define KEYPAD_CLEAR_EN to make key F clear the history instead of shifting in.
module keypad_scan
   import keypad_pkg::*;
#(
   parameter int unsigned DEB_CNT  = 4,
   parameter int unsigned ROW_HOLD = 3
) (
   input  logic        clk190Hz,
   input  logic        rst,
   input  logic [3:0]  col,
   output logic [3:0]  row,
   output logic [3:0]  keyCode,
   output logic        keyValid,
   output logic        keyDown,
   output logic [15:0] dataBus
);

`ifdef KEYPAD_CLEAR_EN
   localparam logic CLEAR_EN = 1'b1;
`else
   localparam logic CLEAR_EN = 1'b0;
`endif

   localparam int unsigned CW = $clog2(DEB_CNT);
   localparam int unsigned DW = $clog2(ROW_HOLD);

   state_t          state;
   logic [1:0]      rowIdx;
   logic [1:0]      colIdx;
   logic [1:0]      rowNext;
   logic [3:0]      latCol;
   logic [3:0]      colS;
   logic [3:0]      code;
   logic [15:0]     busNext;
   logic [DW-1:0]   dwell;
   logic [CW-1:0]   cnt;

   sync2 u_sync (
      .clk190Hz (clk190Hz),
      .rst      (rst),
      .d        (col),
      .q        (colS)
   );

   assign rowNext = rowIdx + 2'd1;
   assign code    = {rowIdx, colIdx};

   always_comb begin
      busNext = {dataBus[11:0], code};
      if (CLEAR_EN && (code == KEY_CLEAR)) busNext = '0;
   end

   // Row changes on the same edge that advances rowIdx, so every evaluated colS
   // was sampled with the current row already driven for the full sync delay.
   always_ff @(posedge clk190Hz or posedge rst) begin
      if (rst) begin
         state    <= SCAN;
         rowIdx   <= '0;
         colIdx   <= '0;
         latCol   <= '0;
         dwell    <= '0;
         cnt      <= '0;
         row      <= '0;
         keyCode  <= '0;
         keyValid <= 1'b0;
         keyDown  <= 1'b0;
         dataBus  <= '0;
      end else begin
         keyValid <= 1'b0;
         unique case (state)
            SCAN: begin
               if (row == '0) begin
                  row <= row_onehot(rowIdx);
               end else if (dwell == DW'(ROW_HOLD - 1)) begin
                  dwell <= '0;
                  if (one_hot4(colS)) begin
                     latCol <= colS;
                     colIdx <= col_index(colS);
                     cnt    <= '0;
                     state  <= DEBOUNCE;
                  end else begin
                     rowIdx <= rowNext;
                     row    <= row_onehot(rowNext);
                  end
               end else begin
                  dwell <= dwell + DW'(1);
               end
            end
            DEBOUNCE: begin
               if (colS == latCol) begin
                  if (cnt == CW'(DEB_CNT - 1)) begin
                     state    <= PRESSED;
                     cnt      <= '0;
                     keyValid <= 1'b1;
                     keyDown  <= 1'b1;
                     keyCode  <= code;
                     dataBus  <= busNext;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end else begin
                  state  <= SCAN;
                  rowIdx <= rowNext;
                  row    <= row_onehot(rowNext);
               end
            end
            PRESSED: begin
               if (colS != '0) begin
                  cnt <= '0;
               end else if (cnt == CW'(DEB_CNT - 1)) begin
                  state   <= SCAN;
                  cnt     <= '0;
                  keyDown <= 1'b0;
                  rowIdx  <= rowNext;
                  row     <= row_onehot(rowNext);
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: state <= SCAN;
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan: a combinational keypad model closes the
// row/column loop; directed tables, corner sequences and a random key stream.
module tb_keypad_scan;

   localparam int DEB_CNT  = 4;
   localparam int ROW_HOLD = 3;

   logic        clk190Hz = 1'b0;
   logic        rst;
   logic [3:0]  col;
   logic [3:0]  row;
   logic [3:0]  keyCode;
   logic        keyValid;
   logic        keyDown;
   logic [15:0] dataBus;

   logic [15:0] pressed;   // bit r*4+c = key at row r, column c held
   int total = 0;
   int bad   = 0;

   logic [3:0] hist[$];

   typedef struct {
      logic [1:0]  r;
      logic [1:0]  c;
      logic [15:0] bus;
   } vec_t;
   vec_t vecs[10];

   keypad_scan #(.DEB_CNT(DEB_CNT), .ROW_HOLD(ROW_HOLD)) dut (
      .clk190Hz (clk190Hz),
      .rst      (rst),
      .col      (col),
      .row      (row),
      .keyCode  (keyCode),
      .keyValid (keyValid),
      .keyDown  (keyDown),
      .dataBus  (dataBus)
   );

   always #5 clk190Hz = ~clk190Hz;

   always_comb begin
      col = '0;
      for (int r = 0; r < 4; r++) begin
         if (row[r]) col = col | pressed[r*4 +: 4];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic watch(input int n, inout int pulses, inout logic [3:0] kc, inout logic [15:0] bus);
      repeat (n) begin
         @(negedge clk190Hz);
         if (keyValid === 1'b1) begin
            pulses++;
            kc  = keyCode;
            bus = dataBus;
         end
      end
   endtask

   task automatic wait_row(input logic [3:0] want, input logic eq, output logic ok);
      ok = 1'b0;
      for (int i = 0; i < 30 && !ok; i++) begin
         @(negedge clk190Hz);
         if ((row == want) == eq) ok = 1'b1;
      end
   endtask

   task automatic do_reset();
      @(negedge clk190Hz);
      rst = 1'b1;
      repeat (2) @(negedge clk190Hz);
      rst = 1'b0;
   endtask

   task automatic do_press(input logic [15:0] mask, input int holdN, input int relN,
                           input int expPulses, input logic [3:0] expCode,
                           input logic [15:0] expBus, input string name);
      int pulses;
      logic [3:0] kc;
      logic [15:0] bus;
      pulses = 0; kc = '0; bus = '0;
      pressed = mask;
      watch(holdN, pulses, kc, bus);
      check({name, " keyDown held"}, 32'(keyDown), 32'(expPulses == 1));
      pressed = '0;
      watch(relN, pulses, kc, bus);
      check({name, " pulses"}, 32'(pulses), 32'(expPulses));
      if (expPulses == 1) begin
         check({name, " keyCode"}, 32'(kc), 32'(expCode));
         check({name, " dataBus"}, 32'(bus), 32'(expBus));
      end
      check({name, " keyDown released"}, 32'(keyDown), 32'd0);
   endtask

   function automatic logic [15:0] model_bus();
      logic [15:0] b;
      b = '0;
      foreach (hist[i]) b = {b[11:0], hist[i]};
      return b;
   endfunction

   initial begin
      int pulses;
      logic [3:0] kc;
      logic [15:0] bus, mask;
      logic ok;
      int r, c1, c2, k;

      vecs[0] = '{2'd0, 2'd1, 16'h0001};
      vecs[1] = '{2'd0, 2'd2, 16'h0012};
      vecs[2] = '{2'd0, 2'd3, 16'h0123};
      vecs[3] = '{2'd1, 2'd0, 16'h1234};
`ifdef KEYPAD_CLEAR_EN
      vecs[4] = '{2'd3, 2'd3, 16'h0000};
      vecs[5] = '{2'd0, 2'd1, 16'h0001};
      vecs[6] = '{2'd0, 2'd2, 16'h0012};
      vecs[7] = '{2'd0, 2'd3, 16'h0123};
`else
      vecs[4] = '{2'd3, 2'd3, 16'h234F};
      vecs[5] = '{2'd0, 2'd1, 16'h34F1};
      vecs[6] = '{2'd0, 2'd2, 16'h4F12};
      vecs[7] = '{2'd0, 2'd3, 16'hF123};
`endif
      vecs[8] = '{2'd1, 2'd0, 16'h1234};
      vecs[9] = '{2'd1, 2'd1, 16'h2345};

      // Reset state and free-running row scan
      pressed = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk190Hz);
      check("reset row", 32'(row), 32'h0);
      check("reset dataBus", 32'(dataBus), 32'h0);
      check("reset keyValid", 32'(keyValid), 32'h0);
      check("reset keyDown", 32'(keyDown), 32'h0);
      check("reset keyCode", 32'(keyCode), 32'h0);
      rst = 1'b0;
      for (int n = 1; n <= 13; n++) begin
         @(negedge clk190Hz);
         check($sformatf("scan row edge %0d", n), 32'(row), 32'(4'b0001 << (((n - 1) / ROW_HOLD) % 4)));
      end

      // Key 9 held 20 clocks; release timing of keyDown
      pulses = 0; kc = '0; bus = '0;
      pressed = 16'h0001 << 9;
      watch(20, pulses, kc, bus);
      check("key9 keyDown held", 32'(keyDown), 32'd1);
      pressed = '0;
      watch(DEB_CNT, pulses, kc, bus);
      check("key9 keyDown still high", 32'(keyDown), 32'd1);
      watch(2, pulses, kc, bus);
      check("key9 keyDown fall", 32'(keyDown), 32'd0);
      check("key9 pulses", 32'(pulses), 32'd1);
      check("key9 keyCode", 32'(kc), 32'h9);
      check("key9 dataBus", 32'(bus), 32'h0009);

      // Bounce: two clocks of contact on row 2
      wait_row(4'b0100, 1'b0, ok);
      wait_row(4'b0100, 1'b1, ok);
      check("bounce row2 reached", 32'(ok), 32'd1);
      pulses = 0;
      pressed = 16'h0001 << 9;
      watch(2, pulses, kc, bus);
      pressed = '0;
      ok = 1'b0;
      for (int i = 0; i < 8 && !ok; i++) begin
         @(negedge clk190Hz);
         if (keyValid === 1'b1) pulses++;
         if (row == 4'b1000) ok = 1'b1;
      end
      check("bounce next row", 32'(ok), 32'd1);
      watch(10, pulses, kc, bus);
      check("bounce pulses", 32'(pulses), 32'd0);
      check("bounce dataBus", 32'(dataBus), 32'h0009);

      // Directed key table from reset
      do_reset();
      foreach (vecs[i]) begin
         do_press(16'h0001 << {vecs[i].r, vecs[i].c}, 30, 12, 1, {vecs[i].r, vecs[i].c},
                  vecs[i].bus, $sformatf("table%0d", i));
      end

      // Ghost: two columns on one row
      do_press(16'h0030, 30, 12, 0, 4'h0, 16'h0, "ghost r1");
      check("ghost dataBus", 32'(dataBus), 32'h2345);

      // Reset during DEBOUNCE, key kept held through release
      wait_row(4'b0100, 1'b0, ok);
      wait_row(4'b0100, 1'b1, ok);
      check("midreset row2 reached", 32'(ok), 32'd1);
      pulses = 0;
      pressed = 16'h0001 << 9;
      watch(4, pulses, kc, bus);
      #1 rst = 1'b1;
      #1;
      check("midreset row", 32'(row), 32'h0);
      check("midreset keyDown", 32'(keyDown), 32'h0);
      check("midreset dataBus", 32'(dataBus), 32'h0);
      check("midreset keyValid", 32'(keyValid), 32'h0);
      check("midreset pulses", 32'(pulses), 32'd0);
      repeat (2) @(negedge clk190Hz);
      rst = 1'b0;
      do_press(16'h0001 << 9, 30, 12, 1, 4'h9, 16'h0009, "redetect");

      // Random key stream against the history model
      do_reset();
      hist.delete();
      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(0, 4) == 0) begin
            r  = int'($urandom_range(0, 3));
            c1 = int'($urandom_range(0, 3));
            c2 = (c1 + 1 + int'($urandom_range(0, 2))) % 4;
            mask = '0;
            mask[r*4 + c1] = 1'b1;
            mask[r*4 + c2] = 1'b1;
            do_press(mask, int'($urandom_range(25, 40)), int'($urandom_range(10, 15)), 0,
                     4'h0, 16'h0, $sformatf("rand%0d ghost", it));
         end else begin
            k = int'($urandom_range(0, 15));
`ifdef KEYPAD_CLEAR_EN
            if (k == 15) hist.delete();
            else hist.push_back(4'(k));
`else
            hist.push_back(4'(k));
`endif
            if (hist.size() > 4) void'(hist.pop_front());
            do_press(16'h0001 << k, int'($urandom_range(25, 40)), int'($urandom_range(10, 15)), 1,
                     4'(k), model_bus(), $sformatf("rand%0d key%0h", it, k));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
